// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle,
// followed by a sign-fixup cycle that writes the HI/LO result registers.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO   = {XLEN{1'b0}};

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   acc_r, mq_r, b_r;
  logic              is_div_r, neg_r, rneg_r;
  logic              signed_op_s, rt_zero_s, div_ge_s;
  logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (ZERO - v) : v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: state_s = MUL;
            OP_DIV, OP_DIVU:   state_s = rt_zero_s ? IDLE : DIV;
            default:           state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL:     state_s = (cnt_r == CNT_LAST) ? FIX : MUL;
      DIV:     state_s = (cnt_r == CNT_LAST) ? FIX : DIV;
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_r != IDLE);
  end

  // Per-iteration arithmetic and final sign fixup
  always_comb begin
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    rt_zero_s   = (rt_val == ZERO);
    mul_sum_s   = {1'b0, acc_r} + {1'b0, (mq_r[0] ? b_r : ZERO)};
    div_sh_s    = {acc_r, mq_r[XLEN-1]};
    div_diff_s  = div_sh_s - {1'b0, b_r};
    div_ge_s    = (div_sh_s >= {1'b0, b_r});
    prod_s      = neg_r ? ({2*XLEN{1'b0}} - {acc_r, mq_r}) : {acc_r, mq_r};
    quot_s      = neg_r ? (ZERO - mq_r) : mq_r;
    rem_s       = rneg_r ? (ZERO - acc_r) : acc_r;
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {CW{1'b0}};
      acc_r       <= ZERO;
      mq_r        <= ZERO;
      b_r         <= ZERO;
      is_div_r    <= 1'b0;
      neg_r       <= 1'b0;
      rneg_r      <= 1'b0;
      hi          <= ZERO;
      lo          <= ZERO;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                // Work on magnitudes; signs are reapplied in FIX
                acc_r       <= ZERO;
                mq_r        <= abs_val(rs_val, signed_op_s);
                b_r         <= abs_val(rt_val, signed_op_s);
                neg_r       <= signed_op_s && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                rneg_r      <= signed_op_s && rs_val[XLEN-1];
                is_div_r    <= op[1];
                cnt_r       <= {CW{1'b0}};
                done        <= op[1] && rt_zero_s;
                div_by_zero <= op[1] && rt_zero_s;
              end
              OP_MTHI: begin
                hi          <= rs_val;
                div_by_zero <= 1'b0;
              end
              OP_MTLO: begin
                lo          <= rs_val;
                div_by_zero <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_r <= mul_sum_s[XLEN:1];
          mq_r  <= {mul_sum_s[0], mq_r[XLEN-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
        end
        DIV: begin
          if (div_ge_s) begin
            acc_r <= div_diff_s[XLEN-1:0];
            mq_r  <= {mq_r[XLEN-2:0], 1'b1};
          end else begin
            acc_r <= div_sh_s[XLEN-1:0];
            mq_r  <= {mq_r[XLEN-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          if (is_div_r) begin
            hi <= rem_s;
            lo <= quot_s;
          end else begin
            {hi, lo} <= prod_s;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, arithmetic corner cases,
// divide-by-zero, MTHI/MTLO, ignored starts and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Present a request for one edge, then scramble operands to show they are not resampled
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b110; rs_val = $urandom; rt_val = $urandom;
  endtask

  // Count busy cycles (bounded) until the unit returns to idle
  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 200) begin
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, required 0/0/0/0/0", busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d busy cycles, required 33", cyc); end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu_result: done=%b hi=%h lo=%h, required 1 fffffffe 00000001", done, hi, lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu_done_pulse: done=%b hi=%h lo=%h, required 0 fffffffe 00000001", done, hi, lo);
    end
  endtask

  task automatic test_mult;
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 33 || done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      n_fail++; $display("FAIL mult_neg: cyc=%0d done=%b hi=%h lo=%h, required 33 1 ffffffff ffffffeb", cyc, done, hi, lo);
    end
    issue(3'b000, 32'h80000000, 32'h80000000);
    wait_idle(cyc);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h40000000 || lo !== 32'h00000000) begin
      n_fail++; $display("FAIL mult_minint: done=%b hi=%h lo=%h, required 1 40000000 00000000", done, hi, lo);
    end
  endtask

  // Each divide is issued in the done cycle of the previous operation
  task automatic test_back_to_back_div;
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_neg: cyc=%0d hi=%h lo=%h, required 33 ffffffff fffffffd", cyc, hi, lo);
    end
    issue(3'b011, 32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_in_done: busy=%b, required 1", busy); end
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 33 || done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++; $display("FAIL divu: cyc=%0d done=%b hi=%h lo=%h, required 33 1 00000002 0000000e", cyc, done, hi, lo);
    end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(cyc);
    n_checks++;
    if (done !== 1'b1 || div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++; $display("FAIL div_overflow: done=%b dbz=%b hi=%h lo=%h, required 1 0 00000000 80000000", done, div_by_zero, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'b100, 32'h12345678, 32'd0);
    n_checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mthi: hi=%h busy=%b done=%b, required 12345678 0 0", hi, busy, done);
    end
    issue(3'b101, 32'hCAFEBABE, 32'd0);
    n_checks++;
    if (lo !== 32'hCAFEBABE || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required 12345678 cafebabe 0 0", hi, lo, busy, done);
    end
    issue(3'b000, 32'd3, 32'd5);
    issue(3'b100, 32'hDEADBEEF, 32'd0);
    n_checks++;
    if (hi !== 32'h12345678 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mthi_while_busy: hi=%h busy=%b, required 12345678 1", hi, busy);
    end
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 32 || hi !== 32'd0 || lo !== 32'd15) begin
      n_fail++; $display("FAIL mult_after_ignored: cyc=%0d hi=%h lo=%h, required 32 00000000 0000000f", cyc, hi, lo);
    end
  endtask

  task automatic test_div_by_zero;
    issue(3'b100, 32'h11111111, 32'd0);
    issue(3'b101, 32'h22222222, 32'd0);
    issue(3'b011, 32'd5, 32'd0);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || div_by_zero !== 1'b1 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      n_fail++; $display("FAIL div_zero: busy=%b done=%b dbz=%b hi=%h lo=%h, required 0 1 1 11111111 22222222", busy, done, div_by_zero, hi, lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL div_zero_hold: done=%b dbz=%b, required 0 1", done, div_by_zero);
    end
    issue(3'b001, 32'd2, 32'd3);
    n_checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL dbz_clear: dbz=%b busy=%b, required 0 1", div_by_zero, busy);
    end
    wait_idle(cyc);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      n_fail++; $display("FAIL multu_small: hi=%h lo=%h, required 00000000 00000006", hi, lo);
    end
  endtask

  task automatic test_reset_mid_op;
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2; rst = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    issue(3'b011, 32'd9, 32'd3);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 33 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd3) begin
      n_fail++; $display("FAIL divu_after_reset: cyc=%0d done=%b hi=%h lo=%h, required 33 1 0 3", cyc, done, hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_back_to_back_div;
    test_mthi_mtlo;
    test_div_by_zero;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
